// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Sequencing controller for the IF_ID / ID_EX / EX_MEM / MEM_WB latches.
// Resolves load-use hazards and taken branches (resolved in MEM) into
// PC-write, latch-write, flush and global-enable strobes, runs a debug
// halt / drain / single-step FSM, and keeps saturating stall and flush
// performance counters.
//
// Ports
//   clk, reset            : system clock, synchronous active-high reset
//   id_ex_MemRead, id_ex_rt: load in EX and its destination register
//   if_id_rs, if_id_rt    : source register fields of the instruction in ID
//   ex_mem_Branch/zero    : branch resolution from the EX_MEM latch
//   mem_busy              : data memory not ready, freeze the pipeline
//   debug_halt            : level request to halt
//   debug_step            : single-cycle advance pulse while halted
//   pc_write, pc_src      : PC enable and branch-target select
//   if_id_write           : IF_ID latch enable
//   *_flush               : bubble insertion into the respective latch
//   pipe_en               : enable for ID_EX, EX_MEM, MEM_WB latches
//   halted                : FSM is in HALT
//   stall_count           : load-use stall cycles (saturating)
//   flush_count           : branch flush events (saturating)
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal execution, hazard/branch/busy rules active
// DRAIN | fetch frozen, bubbles fed into IF_ID until in-flight work retires
// HALT  | pipeline frozen, waiting for step or release
// STEP  | one cycle of RUN behaviour (held while memory is busy)
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int W            = 5,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_ex_MemRead,
    input  logic [W-1:0]     id_ex_rt,
    input  logic [W-1:0]     if_id_rs,
    input  logic [W-1:0]     if_id_rt,
    input  logic             ex_mem_Branch,
    input  logic             ex_mem_zero,
    input  logic             mem_busy,
    input  logic             debug_halt,
    input  logic             debug_step,
    output logic             pc_write,
    output logic             pc_src,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             pipe_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DC_W-1:0]  DRAIN_LAST = DC_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2,
        S_STEP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DC_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic br_taken;
    logic lu_hazard;

    assign br_taken  = ex_mem_Branch & ex_mem_zero;
    assign lu_hazard = id_ex_MemRead & (id_ex_rt != '0) &
                       ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));

    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pipe_en      = 1'b0;
        halted       = 1'b0;

        if (reset) begin
            state_d     = S_RUN;
            drain_cnt_d = '0;
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            case (state_q)
                S_RUN, S_STEP: begin
                    // Busy memory freezes everything, including counters.
                    if (!mem_busy) begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        pipe_en     = 1'b1;
                        if (br_taken) begin
                            pc_src       = 1'b1;
                            if_id_flush  = 1'b1;
                            id_ex_flush  = 1'b1;
                            ex_mem_flush = 1'b1;
                            if (flush_cnt_q != CNT_MAX)
                                flush_cnt_d = flush_cnt_q + 1'b1;
                        end else if (lu_hazard) begin
                            pc_write    = 1'b0;
                            if_id_write = 1'b0;
                            id_ex_flush = 1'b1;
                            if (stall_cnt_q != CNT_MAX)
                                stall_cnt_d = stall_cnt_q + 1'b1;
                        end
                    end
                    if (state_q == S_RUN) begin
                        if (debug_halt) begin
                            state_d     = S_DRAIN;
                            drain_cnt_d = '0;
                        end
                    end else if (!mem_busy) begin
                        state_d = S_HALT;
                    end
                end

                S_DRAIN: begin
                    if (!mem_busy) begin
                        if_id_write = 1'b1;
                        if_id_flush = 1'b1;
                        pipe_en     = 1'b1;
                        // A branch already in MEM must still redirect the PC,
                        // otherwise the halted PC would point at the wrong path.
                        if (br_taken) begin
                            pc_write     = 1'b1;
                            pc_src       = 1'b1;
                            id_ex_flush  = 1'b1;
                            ex_mem_flush = 1'b1;
                            if (flush_cnt_q != CNT_MAX)
                                flush_cnt_d = flush_cnt_q + 1'b1;
                        end
                        if (drain_cnt_q == DRAIN_LAST) begin
                            state_d = S_HALT;
                        end else begin
                            drain_cnt_d = drain_cnt_q + DC_W'(1);
                        end
                    end
                end

                S_HALT: begin
                    halted = 1'b1;
                    if (debug_step) begin
                        state_d = S_STEP;
                    end else if (!debug_halt) begin
                        state_d = S_RUN;
                    end
                end

                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        drain_cnt_q <= drain_cnt_d;
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central sequencing controller for the 5-stage pipeline latches (IF_ID, ID_EX, EX_MEM, MEM_WB). It detects load-use hazards and taken branches resolved in MEM, and generates PC-write, latch-write, flush and global-enable strobes. A debug halt/drain/single-step FSM freezes the pipeline cleanly. It also keeps saturating stall and flush performance counters.

Parameters:
W, 5, register-address width (rs/rt fields)
DRAIN_CYCLES, 4, bubble cycles inserted before HALT so in-flight instructions retire
CNT_W, 16, width of performance counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
id_ex_MemRead  input  1  instruction in EX is a load
id_ex_rt  input  W  load destination register in EX
if_id_rs  input  W  rs field of instruction in ID
if_id_rt  input  W  rt field of instruction in ID
ex_mem_Branch  input  1  m_Branch from EX_MEM latch
ex_mem_zero  input  1  zero flag from EX_MEM latch
mem_busy  input  1  data memory not ready; freeze pipeline
debug_halt  input  1  level request to halt
debug_step  input  1  one-cycle pulse: advance one cycle while halted
pc_write  output  1  PC register enable
pc_src  output  1  1 = load branch target into PC
if_id_write  output  1  IF_ID latch enable
if_id_flush  output  1  zero IF_ID contents (bubble)
id_ex_flush  output  1  zero ID_EX control fields
ex_mem_flush  output  1  zero EX_MEM control fields
pipe_en  output  1  enable for ID_EX, EX_MEM, MEM_WB latches
halted  output  1  state == HALT
stall_count  output  CNT_W  load-use stall cycles, saturating
flush_count  output  CNT_W  branch flush events, saturating

Behaviour:
- Clock is clk; reset is synchronous, active-high. During reset and the cycle it is sampled: state=RUN, drain_cnt=0, both counters 0. Strobe outputs while reset is high: pc_write=0, if_id_write=0, pipe_en=0, all flushes 0, pc_src=0, halted=0.
- Strobes are combinational from state and current inputs, with zero added latency. State, drain_cnt and counters are registered.
- br_taken = ex_mem_Branch & ex_mem_zero.
- lu_hazard = id_ex_MemRead & (id_ex_rt != 0) & (id_ex_rt == if_id_rs | id_ex_rt == if_id_rt).
- Default strobes in RUN/STEP: pc_write=1, if_id_write=1, pipe_en=1, flushes=0, pc_src=0.
- Priority in RUN/STEP: mem_busy > br_taken > lu_hazard.
  - mem_busy: pc_write=0, if_id_write=0, pipe_en=0, no flush, no counter update.
  - br_taken: pc_src=1, pc_write=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1. flush_count+1.
  - lu_hazard (no branch): pc_write=0, if_id_write=0, id_ex_flush=1, pipe_en=1. stall_count+1.
- Counters saturate at all-ones and never wrap.
- FSM states: RUN, DRAIN, HALT, STEP.
  - RUN: debug_halt=1 -> DRAIN, drain_cnt<=0. The current cycle still behaves as RUN.
  - DRAIN: pc_write=0, if_id_write=1, if_id_flush=1, pipe_en=1.
    - br_taken in DRAIN: pc_write=1, pc_src=1, id_ex_flush=1, ex_mem_flush=1, flush_count+1.
    - mem_busy in DRAIN: full freeze as above; drain_cnt holds.
    - Otherwise drain_cnt+1. When drain_cnt==DRAIN_CYCLES-1 on a non-busy cycle -> HALT.
    - debug_halt deasserting in DRAIN does not abort the drain; the block still reaches HALT.
  - HALT: pc_write=0, if_id_write=0, pipe_en=0, flushes 0, halted=1.
    - debug_step=1 -> STEP (step wins if debug_halt is also 0).
    - Else debug_halt=0 -> RUN.
  - STEP: exactly one cycle of RUN strobes, with hazard/branch/busy rules applied.
    - If mem_busy, stay in STEP until a non-busy cycle, then -> HALT.
    - debug_step pulses outside HALT are ignored.
- Reset asserted in any state returns the block to RUN on the next edge. Counters clear.

Test Plan:
- lw r2 in EX (id_ex_MemRead=1, id_ex_rt=2), ID has rs=2 -> same cycle pc_write=0, if_id_write=0, id_ex_flush=1; stall_count 0->1. Repeat with id_ex_rt=0 -> no stall.
- ex_mem_Branch=1, ex_mem_zero=1 together with lu_hazard=1 -> pc_src=1, all three flushes=1, pc_write=1; flush_count=1, stall_count unchanged. Adding mem_busy=1 -> all enables 0, no flush, counters unchanged.
- debug_halt=1 in RUN -> 4 DRAIN cycles with if_id_flush=1, pc_write=0, then halted=1 on cycle 5. mem_busy for 2 cycles mid-drain -> halted on cycle 7.
- In HALT, pulse debug_step -> exactly one cycle with pc_write=1, pipe_en=1, then halted=1 again. Drop debug_halt -> RUN next cycle.
- Reset asserted during DRAIN with drain_cnt=2 -> next cycle state RUN, halted=0, counters 0, strobes 0 while reset is high.
- Force stall_count to 0xFFFF via repeated hazards (or a reduced CNT_W=4 build: 15 stalls) -> a further hazard leaves the counter at all-ones.
